// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU op codes, exception bit indices, bus size codes
// and the memory-stage FSM state type.
package cpu_pkg;

    localparam logic [7:0] ALUOP_ADDU = 8'b0010_0001;
    localparam logic [7:0] ALUOP_LB   = 8'b1110_0000;
    localparam logic [7:0] ALUOP_LH   = 8'b1110_0001;
    localparam logic [7:0] ALUOP_LW   = 8'b1110_0011;
    localparam logic [7:0] ALUOP_LBU  = 8'b1110_0100;
    localparam logic [7:0] ALUOP_LHU  = 8'b1110_0101;
    localparam logic [7:0] ALUOP_SB   = 8'b1110_1000;
    localparam logic [7:0] ALUOP_SH   = 8'b1110_1001;
    localparam logic [7:0] ALUOP_SW   = 8'b1110_1011;

    localparam int unsigned EXC_ADEL = 4;
    localparam int unsigned EXC_ADES = 5;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        DONE
    } mem_state_t;

endpackage

// File: rtl/mem_access_if.sv
// SRAM-like data bus: request/address phase closed by addr_ok, data phase by data_ok.
interface mem_access_if;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        output data_addr_ok, data_data_ok, data_rdata
    );

endinterface

// File: rtl/mem_align.sv
// Load/store decode: alignment check, store lane replication and strobes,
// load lane selection with sign/zero extension.
module mem_align import cpu_pkg::*; (
    input  logic [7:0]  aluop,
    input  logic [1:0]  offset,
    input  logic [31:0] store_src,
    input  logic [31:0] rdata,
    output logic        is_load,
    output logic        is_store,
    output logic        misaligned,
    output logic [1:0]  size,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    output logic [31:0] load_data
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    // Select the addressed byte / halfword from the little-endian read word.
    always_comb begin
        case (offset)
            2'd0:    byte_lane = rdata[7:0];
            2'd1:    byte_lane = rdata[15:8];
            2'd2:    byte_lane = rdata[23:16];
            default: byte_lane = rdata[31:24];
        endcase
        half_lane = offset[1] ? rdata[31:16] : rdata[15:0];
    end

    // Decode the op into bus size, alignment fault, store formatting and load extension.
    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        misaligned = 1'b0;
        size       = SIZE_WORD;
        wdata      = store_src;
        wstrb      = '0;
        load_data  = rdata;
        case (aluop)
            ALUOP_LB: begin
                is_load   = 1'b1;
                size      = SIZE_BYTE;
                load_data = {{24{byte_lane[7]}}, byte_lane};
            end
            ALUOP_LBU: begin
                is_load   = 1'b1;
                size      = SIZE_BYTE;
                load_data = {24'b0, byte_lane};
            end
            ALUOP_LH: begin
                is_load    = 1'b1;
                size       = SIZE_HALF;
                misaligned = offset[0];
                load_data  = {{16{half_lane[15]}}, half_lane};
            end
            ALUOP_LHU: begin
                is_load    = 1'b1;
                size       = SIZE_HALF;
                misaligned = offset[0];
                load_data  = {16'b0, half_lane};
            end
            ALUOP_LW: begin
                is_load    = 1'b1;
                misaligned = (offset != 2'b00);
            end
            ALUOP_SB: begin
                is_store = 1'b1;
                size     = SIZE_BYTE;
                wdata    = {4{store_src[7:0]}};
                wstrb    = 4'b0001 << offset;
            end
            ALUOP_SH: begin
                is_store   = 1'b1;
                size       = SIZE_HALF;
                misaligned = offset[0];
                wdata      = {2{store_src[15:0]}};
                wstrb      = offset[1] ? 4'b1100 : 4'b0011;
            end
            ALUOP_SW: begin
                is_store   = 1'b1;
                misaligned = (offset != 2'b00);
                wstrb      = 4'b1111;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// MEM pipeline stage: drives the data bus for loads/stores, raises address
// exceptions, stalls the pipeline while a transaction is outstanding and
// presents the write-back / forwarding stream.
module mem_access import cpu_pkg::*; (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic [31:0] pc_i,
    input  logic [7:0]  aluop_i,
    input  logic [31:0] exception_type_i,
    input  logic        now_in_delayslot_i,
    input  logic [31:0] alu_data_i,
    input  logic [31:0] ram_write_data_i,
    input  logic        regfile_write_enable_i,
    input  logic [4:0]  regfile_write_addr_i,
    input  logic        hi_write_enable_i,
    input  logic [31:0] hi_write_data_i,
    input  logic        lo_write_enable_i,
    input  logic [31:0] lo_write_data_i,
    input  logic        cp0_write_enable_i,
    input  logic [4:0]  cp0_write_addr_i,
    input  logic [31:0] cp0_write_data_i,
    input  logic        flush_i,
    input  logic        pipeline_stall_i,
    mem_access_if.master bus,
    output logic        regfile_write_enable_o,
    output logic [4:0]  regfile_write_addr_o,
    output logic [31:0] regfile_write_data_o,
    output logic        hi_write_enable_o,
    output logic [31:0] hi_write_data_o,
    output logic        lo_write_enable_o,
    output logic [31:0] lo_write_data_o,
    output logic        cp0_write_enable_o,
    output logic [4:0]  cp0_write_addr_o,
    output logic [31:0] cp0_write_data_o,
    output logic [31:0] exception_type_o,
    output logic [31:0] bad_vaddr_o,
    output logic [31:0] pc_o,
    output logic        now_in_delayslot_o,
    output logic        mem_stall_request_o
);

    mem_state_t  state;
    logic        cancel;
    logic [31:0] rdata_q;

    logic        is_load;
    logic        is_store;
    logic        misaligned;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] load_data;
    logic        go;
    logic        cancel_now;

    mem_align u_align (
        .aluop      (aluop_i),
        .offset     (alu_data_i[1:0]),
        .store_src  (ram_write_data_i),
        .rdata      (rdata_q),
        .is_load    (is_load),
        .is_store   (is_store),
        .misaligned (misaligned),
        .size       (size),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .load_data  (load_data)
    );

    assign go = (is_load || is_store) && !misaligned && (exception_type_i == '0);

    // A flush arriving mid-transaction cancels the result but not the bus handshake.
    assign cancel_now = cancel || (flush_i && (state == ADDR || state == DATA));

    // Bus transaction sequencing; a cancelled transaction drains its data_ok and drops the data.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state   <= IDLE;
            cancel  <= 1'b0;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    cancel <= 1'b0;
                    if (go && !flush_i)
                        state <= bus.data_addr_ok ? DATA : ADDR;
                end
                ADDR: begin
                    if (flush_i)
                        cancel <= 1'b1;
                    if (bus.data_addr_ok)
                        state <= DATA;
                end
                DATA: begin
                    if (bus.data_data_ok) begin
                        cancel <= 1'b0;
                        if (cancel_now) begin
                            state <= IDLE;
                        end else begin
                            rdata_q <= bus.data_rdata;
                            state   <= DONE;
                        end
                    end else if (flush_i) begin
                        cancel <= 1'b1;
                    end
                end
                DONE: begin
                    if (!pipeline_stall_i)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Reset gates the combinational request path so the bus goes quiet before any clock edge.
    assign bus.data_req   = !reset_i && (state == IDLE ? (go && !flush_i) : (state == ADDR));
    assign bus.data_wr    = !reset_i && is_store;
    assign bus.data_size  = size;
    assign bus.data_addr  = alu_data_i;
    assign bus.data_wdata = wdata;
    assign bus.data_wstrb = (!reset_i && is_store) ? wstrb : '0;

    assign mem_stall_request_o = !reset_i && go && (state != DONE) && !(state == IDLE && flush_i);

    assign regfile_write_enable_o = regfile_write_enable_i && !misaligned && !cancel_now;
    assign regfile_write_addr_o   = regfile_write_addr_i;
    assign regfile_write_data_o   = is_load ? load_data : alu_data_i;
    assign hi_write_enable_o      = hi_write_enable_i && !misaligned;
    assign hi_write_data_o        = hi_write_data_i;
    assign lo_write_enable_o      = lo_write_enable_i && !misaligned;
    assign lo_write_data_o        = lo_write_data_i;
    assign cp0_write_enable_o     = cp0_write_enable_i && !misaligned;
    assign cp0_write_addr_o       = cp0_write_addr_i;
    assign cp0_write_data_o       = cp0_write_data_i;
    assign bad_vaddr_o            = alu_data_i;
    assign pc_o                   = pc_i;
    assign now_in_delayslot_o     = now_in_delayslot_i;

    // Merge the alignment faults into the incoming exception vector.
    always_comb begin
        exception_type_o           = exception_type_i;
        exception_type_o[EXC_ADEL] = exception_type_i[EXC_ADEL] | (is_load && misaligned);
        exception_type_o[EXC_ADES] = exception_type_i[EXC_ADES] | (is_store && misaligned);
    end

endmodule
